cache_arbiter: RTL and testbench

- Sits directly downstream of the instruction cache and the data cache, and directly upstream of physical memory.
- Multiplexes the two caches' single-line physical-memory requests onto one pmem port.
- Each request is a 128-bit lc3b_block read or write-back.
- Requests are latched at grant and served one at a time, with round-robin fairness when both caches request together.

---
 rtl/cache_arbiter_if.sv | 43 ++++
 rtl/cache_arbiter.sv | 74 +++++++
 tb/tb_cache_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Cache-side and pmem-side signals of the I/D cache to physical-memory arbiter.
// slave = arbiter view, master = caches + memory view.
interface cache_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;

  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output icache_pmem_read, icache_pmem_address,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter serialising icache fills and dcache fills/write-backs onto one pmem port.
// Requests are latched at grant; every output comes from registered state.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input logic            clk,
  input logic            reset,
  cache_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} client_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } req_t;

  state_t            state, state_nxt;
  client_t           grant, grant_nxt;
  req_t              req_q, req_nxt;
  logic [LINE_W-1:0] rdata_q;
  logic              i_req, d_req;

  assign i_req = bus.icache_pmem_read;
  assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

  // grant doubles as the round-robin pointer: it names the most recent winner.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    req_nxt   = req_q;
    case (state)
      IDLE: begin
        if (i_req | d_req) begin
          if (i_req && d_req) grant_nxt = (grant == DCACHE) ? ICACHE : DCACHE;
          else                grant_nxt = d_req ? DCACHE : ICACHE;
          req_nxt.write = (grant_nxt == DCACHE) & bus.dcache_pmem_write;
          req_nxt.addr  = (grant_nxt == DCACHE) ? bus.dcache_pmem_address
                                                : bus.icache_pmem_address;
          if (req_nxt.write) req_nxt.wdata = bus.dcache_pmem_wdata;
          state_nxt = BUSY;
        end
      end
      BUSY:    if (bus.pmem_resp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= DCACHE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      req_q <= req_nxt;
      if (state == BUSY && bus.pmem_resp) rdata_q <= bus.pmem_rdata;
    end
  end

  assign bus.pmem_read         = (state == BUSY) & ~req_q.write;
  assign bus.pmem_write        = (state == BUSY) &  req_q.write;
  assign bus.pmem_address      = req_q.addr;
  assign bus.pmem_wdata        = req_q.wdata;
  assign bus.icache_pmem_resp  = (state == DONE) & (grant == ICACHE);
  assign bus.dcache_pmem_resp  = (state == DONE) & (grant == DCACHE);
  assign bus.icache_pmem_rdata = rdata_q;
  assign bus.dcache_pmem_rdata = rdata_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus random clients and a random-latency
// memory, all scored against a transaction-level model of the arbitration rules.
module tb_cache_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();
  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // model: one transaction at a time, owner 0 = icache, 1 = dcache
  typedef enum {P_IDLE, P_BUSY, P_DONE} phase_t;
  phase_t            m_phase = P_IDLE;
  int                m_owner = 0;
  int                m_last  = 1;
  bit                m_write = 0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [LINE_W-1:0] m_wdata = '0;
  logic [LINE_W-1:0] m_rdata = '0;

  int resp_log[$];
  int n_iresp = 0, n_dresp = 0, n_pread = 0, n_pwrite = 0;

  bit                rnd_mode = 0;
  bit                hold     = 0;
  bit                pm_fixed = 0;
  int                lat_cfg  = 0;
  int                pm_wait  = -1;
  logic [LINE_W-1:0] pm_data  = '0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Inputs seen here are those sampled at the preceding posedge; outputs are its result.
  task automatic monitor();
    bit ireq, dreq;
    if (reset) begin
      m_phase = P_IDLE; m_last = 1; m_rdata = '0;
      chk("rst_pmem_read",    LINE_W'(bus.pmem_read),        '0);
      chk("rst_pmem_write",   LINE_W'(bus.pmem_write),       '0);
      chk("rst_pmem_address", LINE_W'(bus.pmem_address),     '0);
      chk("rst_pmem_wdata",   bus.pmem_wdata,                '0);
      chk("rst_icache_resp",  LINE_W'(bus.icache_pmem_resp), '0);
      chk("rst_dcache_resp",  LINE_W'(bus.dcache_pmem_resp), '0);
      chk("rst_rdata",        bus.icache_pmem_rdata,         '0);
      return;
    end
    ireq = bus.icache_pmem_read;
    dreq = bus.dcache_pmem_read | bus.dcache_pmem_write;
    case (m_phase)
      P_IDLE: if (ireq || dreq) begin
        m_owner = (ireq && dreq) ? 1 - m_last : (dreq ? 1 : 0);
        m_last  = m_owner;
        m_write = (m_owner == 1) && bus.dcache_pmem_write;
        m_addr  = (m_owner == 1) ? bus.dcache_pmem_address : bus.icache_pmem_address;
        if (m_write) m_wdata = bus.dcache_pmem_wdata;
        m_phase = P_BUSY;
      end
      P_BUSY: if (bus.pmem_resp) begin
        m_rdata = bus.pmem_rdata;
        m_phase = P_DONE;
      end
      P_DONE: m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
    chk("pmem_read",  LINE_W'(bus.pmem_read),  LINE_W'(m_phase == P_BUSY && !m_write));
    chk("pmem_write", LINE_W'(bus.pmem_write), LINE_W'(m_phase == P_BUSY && m_write));
    if (m_phase == P_BUSY) chk("pmem_address", LINE_W'(bus.pmem_address), LINE_W'(m_addr));
    if (m_phase == P_BUSY && m_write) chk("pmem_wdata", bus.pmem_wdata, m_wdata);
    chk("icache_resp",  LINE_W'(bus.icache_pmem_resp), LINE_W'(m_phase == P_DONE && m_owner == 0));
    chk("dcache_resp",  LINE_W'(bus.dcache_pmem_resp), LINE_W'(m_phase == P_DONE && m_owner == 1));
    chk("icache_rdata", bus.icache_pmem_rdata, m_rdata);
    chk("dcache_rdata", bus.dcache_pmem_rdata, m_rdata);
    if (bus.icache_pmem_resp) begin resp_log.push_back(0); n_iresp++; end
    if (bus.dcache_pmem_resp) begin resp_log.push_back(1); n_dresp++; end
    if (bus.pmem_read)  n_pread++;
    if (bus.pmem_write) n_pwrite++;
  endtask

  task automatic rand_clients();
    int cmd;
    if (!bus.icache_pmem_read) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.icache_pmem_read    = 1'b1;
        bus.icache_pmem_address = ADDR_W'($urandom);
      end
    end else if ($urandom_range(0, 1) == 0) bus.icache_pmem_address = ADDR_W'($urandom);
    if (!(bus.dcache_pmem_read || bus.dcache_pmem_write)) begin
      if ($urandom_range(0, 3) == 0) begin
        cmd = int'($urandom_range(0, 2));
        bus.dcache_pmem_read    = (cmd != 1);
        bus.dcache_pmem_write   = (cmd != 0);
        bus.dcache_pmem_address = ADDR_W'($urandom);
        bus.dcache_pmem_wdata   = rand128();
      end
    end else if ($urandom_range(0, 1) == 0) begin
      bus.dcache_pmem_address = ADDR_W'($urandom);
      bus.dcache_pmem_wdata   = rand128();
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    if (!hold && bus.icache_pmem_resp) bus.icache_pmem_read = 1'b0;
    if (!hold && bus.dcache_pmem_resp) begin
      bus.dcache_pmem_read  = 1'b0;
      bus.dcache_pmem_write = 1'b0;
    end
    // memory: answer after a few cycles, occasionally pulse resp with nothing pending
    if (reset) begin
      bus.pmem_resp = 1'b0; pm_wait = -1;
    end else if (bus.pmem_resp) begin
      bus.pmem_resp = 1'b0;
    end else if (bus.pmem_read || bus.pmem_write) begin
      if (pm_wait < 0) pm_wait = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
      if (pm_wait == 0) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = pm_fixed ? pm_data : rand128();
        pm_wait = -1;
      end else pm_wait--;
    end else if (rnd_mode && $urandom_range(0, 19) == 0) begin
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = rand128();
    end
    if (rnd_mode) rand_clients();
  endtask

  task automatic drain(input string tag, input int max);
    bit done = 0;
    for (int n = 0; n < max && !done; n++) begin
      cycle();
      done = !bus.icache_pmem_read && !bus.dcache_pmem_read && !bus.dcache_pmem_write &&
             m_phase == P_IDLE;
    end
    chk(tag, LINE_W'(done), LINE_W'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.icache_pmem_read = 1'b0; bus.dcache_pmem_read = 1'b0; bus.dcache_pmem_write = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  initial begin
    int i0, d0, pr0, pw0, nr;
    bit got;
    logic [LINE_W-1:0] keep;
    reset = 1'b1;
    bus.icache_pmem_read = 1'b0; bus.icache_pmem_address = '0;
    bus.dcache_pmem_read = 1'b0; bus.dcache_pmem_write = 1'b0;
    bus.dcache_pmem_address = '0; bus.dcache_pmem_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    do_reset();

    // icache-only read, slow memory with a fixed pattern
    lat_cfg = 4; pm_fixed = 1; pm_data = {16{8'hA5}};
    i0 = n_iresp; d0 = n_dresp;
    bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 16'h1230;
    drain("t1_done", 30);
    chk("t1_iresp_cnt", LINE_W'(n_iresp - i0), LINE_W'(1));
    chk("t1_dresp_cnt", LINE_W'(n_dresp - d0), '0);
    chk("t1_rdata", bus.icache_pmem_rdata, {16{8'hA5}});
    pm_fixed = 0;

    // dcache write-back with wdata/address scrambled once latched
    lat_cfg = 3; d0 = n_dresp; pr0 = n_pread; pw0 = n_pwrite;
    bus.dcache_pmem_write = 1'b1; bus.dcache_pmem_address = 16'h4560;
    bus.dcache_pmem_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    cycle(); cycle();
    chk("t2_pmem_write", LINE_W'(bus.pmem_write), LINE_W'(1));
    bus.dcache_pmem_wdata = ~bus.dcache_pmem_wdata; bus.dcache_pmem_address = 16'hFFFF;
    cycle();
    chk("t2_wdata_held", bus.pmem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("t2_addr_held", LINE_W'(bus.pmem_address), LINE_W'(16'h4560));
    drain("t2_done", 30);
    chk("t2_dresp_cnt", LINE_W'(n_dresp - d0), LINE_W'(1));
    chk("t2_no_read", LINE_W'(n_pread - pr0), '0);
    chk("t2_write_seen", LINE_W'(n_pwrite - pw0 > 0), LINE_W'(1));

    // simultaneous requests held continuously after reset: I, D, I, D
    do_reset();
    lat_cfg = 0; hold = 1; resp_log.delete();
    bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 16'h0100;
    bus.dcache_pmem_read = 1'b1; bus.dcache_pmem_address = 16'h0200;
    for (int n = 0; n < 60 && resp_log.size() < 4; n++) cycle();
    hold = 0;
    bus.icache_pmem_read = 1'b0; bus.dcache_pmem_read = 1'b0;
    drain("t3_done", 30);
    chk("t3_count", LINE_W'(resp_log.size() >= 4), LINE_W'(1));
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_order%0d", k), LINE_W'(resp_log.size() > k ? resp_log[k] : -1), LINE_W'(k % 2));

    // dcache read and write both high: treated as a write
    lat_cfg = 1; pr0 = n_pread; pw0 = n_pwrite;
    bus.dcache_pmem_read = 1'b1; bus.dcache_pmem_write = 1'b1;
    bus.dcache_pmem_address = 16'h0080; bus.dcache_pmem_wdata = rand128();
    drain("t4_done", 30);
    chk("t4_no_read", LINE_W'(n_pread - pr0), '0);
    chk("t4_write_seen", LINE_W'(n_pwrite - pw0 > 0), LINE_W'(1));

    // reset in the middle of a read
    lat_cfg = 8; got = 0;
    bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 16'h2222;
    for (int n = 0; n < 10 && !got; n++) begin cycle(); got = bus.pmem_read; end
    chk("t5_busy_reached", LINE_W'(got), LINE_W'(1));
    #2 reset = 1'b1;
    #1;
    chk("t5_read_drop", LINE_W'(bus.pmem_read), '0);
    chk("t5_addr_clr", LINE_W'(bus.pmem_address), '0);
    chk("t5_iresp", LINE_W'(bus.icache_pmem_resp), '0);
    bus.icache_pmem_read = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    nr = n_iresp + n_dresp;
    bus.pmem_resp = 1'b1; bus.pmem_rdata = rand128();
    cycle(); cycle(); cycle();
    chk("t5_no_resp", LINE_W'(n_iresp + n_dresp - nr), '0);
    lat_cfg = 0; resp_log.delete();
    bus.icache_pmem_read = 1'b1; bus.dcache_pmem_read = 1'b1;
    drain("t5_done", 40);
    chk("t5_first_icache", LINE_W'(resp_log.size() > 0 ? resp_log[0] : -1), '0);

    // stray pmem_resp while idle
    keep = bus.icache_pmem_rdata; nr = n_iresp + n_dresp;
    bus.pmem_resp = 1'b1; bus.pmem_rdata = ~keep;
    cycle(); cycle(); cycle();
    chk("t6_rdata_kept", bus.icache_pmem_rdata, keep);
    chk("t6_no_resp", LINE_W'(n_iresp + n_dresp - nr), '0);

    // random traffic
    rnd_mode = 1; lat_cfg = -1; nr = n_iresp + n_dresp;
    for (int n = 0; n < 2000; n++) cycle();
    rnd_mode = 0;
    drain("rnd_done", 60);
    chk("rnd_traffic", LINE_W'(n_iresp + n_dresp - nr > 50), LINE_W'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
